gray_ptr_sync: RTL
==================

# gray_ptr_sync

Parametrised FIFO pointer synchronizer with N-stage Gray synchronization, Gray-to-binary decode, and the full/empty and level logic for the receiving domain. One instance sits in the read domain (MODE=0) to import the write pointer, and one sits in the write domain (MODE=1) to import the read pointer. The source pointer is Gray-coded and registered in its own domain before it reaches this block.

## Interface
- ADDR_WIDTH, 5, FIFO address bits; pointers are ADDR_WIDTH+1 bits (MSB = wrap bit)
- SYNC_STAGES, 2, synchronizer flop depth, legal range 2..4
- MODE, 0, 0 = empty side (remote = write ptr), 1 = full side (remote = read ptr)

- clk  in  1  receiving-domain clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on clk rising edge
- remote_ptr_gray  in  ADDR_WIDTH+1  Gray pointer from the other domain (asynchronous)
- local_ptr  in  ADDR_WIDTH+1  binary pointer owned by this domain
- sync_ptr_gray  out  ADDR_WIDTH+1  last synchronizer stage
- sync_ptr_bin  out  ADDR_WIDTH+1  registered binary decode of sync_ptr_gray
- advance  out  1  one-cycle pulse when sync_ptr_bin changes
- level  out  ADDR_WIDTH+1  MODE0: sync_ptr_bin − local_ptr; MODE1: local_ptr − sync_ptr_bin; modulo 2^(ADDR_WIDTH+1)
- flag  out  1  MODE0: empty; MODE1: full
- gray_err  out  1  sticky: consecutive synchronized samples differ in more than one bit

## Operation
- Sync chain: SYNC_STAGES registers. Stage 0 samples remote_ptr_gray, and each later stage samples the previous one. sync_ptr_gray is the last stage.
- Decode: bin[MSB] = gray[MSB]; bin[i] = bin[i+1] ^ gray[i]. The result is registered into sync_ptr_bin.
- advance = registered (decoded value ≠ current sync_ptr_bin).
- Error check: compare sync_ptr_gray with its value one cycle earlier. If popcount(XOR) > 1, set gray_err. gray_err stays set until reset.
- flag and level are combinational from registered sync_ptr_bin and live local_ptr, so they respond in the same cycle that local_ptr changes.
  - MODE0: flag = (sync_ptr_bin == local_ptr).
  - MODE1: flag = (MSBs differ) && (lower ADDR_WIDTH bits equal).
- Wrap-around: all subtraction is modulo 2^(ADDR_WIDTH+1) with no saturation. level never exceeds 2^ADDR_WIDTH in legal operation.
- Reset: every chain stage, sync_ptr_gray, sync_ptr_bin, advance, gray_err and the previous-sample register are cleared to 0.
  - After reset with local_ptr = 0: MODE0 flag = 1 (empty), MODE1 flag = 0 (not full), level = 0.
- Reset asserted mid-operation clears everything on that edge. The chain then refills from remote_ptr_gray, and no gray_err is raised by the post-reset transition. The previous-sample register is also reset, so the first compare is against 0; a nonzero remote pointer at release is masked for SYNC_STAGES+1 cycles after reset.

## Timing
- remote_ptr_gray → sync_ptr_gray: SYNC_STAGES edges.
- remote_ptr_gray → sync_ptr_bin / advance: SYNC_STAGES+1 edges.
- local_ptr → flag / level: 0 cycles (combinational).
- Simultaneous remote and local changes: the flag reflects the new local_ptr and the old sync_ptr_bin that cycle. This is conservative by construction: empty or full may be reported late, never early.
- Throughput: one remote pointer update per clk is tracked as long as the source changes by at most one Gray step per sample.

## Structure
- Shared package (fifo_pkg):
  - mode constants MODE_EMPTY = 0 and MODE_FULL = 1
  - gray-to-binary and binary-to-gray functions parametrised on width
- Sub-module gray_to_bin: combinational decode of width ADDR_WIDTH+1, reused by the write-side Gray encoder's checker.
- The chain is a generate loop over SYNC_STAGES. A parameter check rejects SYNC_STAGES < 2.

## Test plan
- Reset: assert reset with remote_ptr_gray = 6'b000011 → all outputs 0 except flag = 1 (MODE0). The first nonzero sync_ptr_gray appears SYNC_STAGES edges after release, with gray_err = 0.
- Latency, SYNC_STAGES = 3, MODE0: remote_ptr_gray goes 0 → 1 at edge k → sync_ptr_bin = 1 and advance = 1 at edge k+4. Then local_ptr = 1 → flag = 1 in the same cycle, level = 0.
- Full, MODE1, ADDR_WIDTH = 5: remote read pointer binary 3 (Gray 6'b000010) and local_ptr = 35 → flag = 1, level = 32. Change local_ptr to 34 → flag = 0, level = 31.
- Wrap: step remote Gray through all 64 codes, passing 63 → 0 → sync_ptr_bin follows 62, 63, 0, 1. advance pulses each step, gray_err stays 0, and with local_ptr = 62 level reads 0, 1, 2, 3.
- Illegal jump: drive remote_ptr_gray 0 → 6'b000011 in one step → gray_err = 1 at SYNC_STAGES+1 edges and stays set. A synchronous reset clears it.
- Mid-operation reset, MODE0: level = 5, then reset held for one edge → sync_ptr_bin = 0, level = 0 (local_ptr = 0), flag = 1. Afterwards the block resynchronizes to remote_ptr_gray within SYNC_STAGES+1 edges.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared FIFO constants and Gray/binary conversion helpers.
// Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int MODE_EMPTY = 0;
    localparam int MODE_FULL  = 1;

    // The helpers work at a fixed maximum width. Narrower pointers are
    // zero-extended on the way in, which leaves both conversions unchanged.
    localparam int c_max_ptr_w = 32;

    function automatic logic [c_max_ptr_w-1:0] gray2bin(input logic [c_max_ptr_w-1:0] gray);
        logic [c_max_ptr_w-1:0] bin;
        bin[c_max_ptr_w-1] = gray[c_max_ptr_w-1];
        for (int i = c_max_ptr_w - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [c_max_ptr_w-1:0] bin2gray(input logic [c_max_ptr_w-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_bin
// Description : Combinational Gray-to-binary decode of a WIDTH-bit pointer.
// Revision    : 1.0  initial release
// ============================================================================
module gray_to_bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = 6
)
(
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    generate
        if (WIDTH < 1 || WIDTH > c_max_ptr_w) begin : g_width_check
            $error("gray_to_bin: WIDTH out of range");
        end
    endgenerate

    assign bin = WIDTH'(gray2bin(c_max_ptr_w'(gray)));

endmodule
`default_nettype wire

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : gray_ptr_sync
// Description : FIFO pointer synchronizer with Gray decode, level and
//               empty/full flag for the receiving clock domain.
// Revision    : 1.0  initial release
// ============================================================================
module gray_ptr_sync
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = MODE_EMPTY
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_WIDTH:0] remote_ptr_gray,
    input  logic [ADDR_WIDTH:0] local_ptr,
    output logic [ADDR_WIDTH:0] sync_ptr_gray,
    output logic [ADDR_WIDTH:0] sync_ptr_bin,
    output logic                advance,
    output logic [ADDR_WIDTH:0] level,
    output logic                flag,
    output logic                gray_err
);

    localparam int c_ptr_w  = ADDR_WIDTH + 1;
    localparam int c_mask_w = $clog2(SYNC_STAGES + 2);
    localparam logic [c_mask_w-1:0] c_mask_init = c_mask_w'(SYNC_STAGES + 1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_stages_check
            $error("gray_ptr_sync: SYNC_STAGES must be in 2..4");
        end
        if (MODE != MODE_EMPTY && MODE != MODE_FULL) begin : g_mode_check
            $error("gray_ptr_sync: MODE must be 0 or 1");
        end
    endgenerate

    logic [ADDR_WIDTH:0] r_sync [SYNC_STAGES];
    logic [ADDR_WIDTH:0] r_sync_bin;
    logic [ADDR_WIDTH:0] r_prev_gray;
    logic                r_advance;
    logic                r_gray_err;
    logic [c_mask_w-1:0] r_mask_cnt;

    logic [ADDR_WIDTH:0] w_sync_last;
    logic [ADDR_WIDTH:0] w_decoded;
    logic [ADDR_WIDTH:0] w_gray_diff;
    logic                w_multi_bit;
    logic [ADDR_WIDTH:0] w_level;
    logic                w_flag;

    generate
        for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_chain
            if (i == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_sync[i] <= '0;
                    end else begin
                        r_sync[i] <= remote_ptr_gray;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_sync[i] <= '0;
                    end else begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
        end
    endgenerate

    assign w_sync_last = r_sync[SYNC_STAGES-1];

    gray_to_bin #(
        .WIDTH (c_ptr_w)
    ) u_decode (
        .gray (w_sync_last),
        .bin  (w_decoded)
    );

    // A nonzero value has at least two set bits iff clearing its lowest set bit leaves something.
    assign w_gray_diff = w_sync_last ^ r_prev_gray;
    assign w_multi_bit = (w_gray_diff & (w_gray_diff - c_ptr_w'(1))) != '0;

    // Hides the reset-to-live step while the chain refills after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask_cnt <= c_mask_init;
        end else if (r_mask_cnt != '0) begin
            r_mask_cnt <= r_mask_cnt - c_mask_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_bin  <= '0;
            r_advance   <= 1'b0;
            r_prev_gray <= '0;
            r_gray_err  <= 1'b0;
        end else begin
            r_sync_bin  <= w_decoded;
            r_advance   <= (w_decoded != r_sync_bin);
            r_prev_gray <= w_sync_last;
            if (w_multi_bit && (r_mask_cnt == '0)) begin
                r_gray_err <= 1'b1;
            end
        end
    end

    generate
        if (MODE == MODE_FULL) begin : g_full_side
            assign w_level = local_ptr - r_sync_bin;
            assign w_flag  = (local_ptr[ADDR_WIDTH] != r_sync_bin[ADDR_WIDTH]) &&
                             (local_ptr[ADDR_WIDTH-1:0] == r_sync_bin[ADDR_WIDTH-1:0]);
        end else begin : g_empty_side
            assign w_level = r_sync_bin - local_ptr;
            assign w_flag  = (r_sync_bin == local_ptr);
        end
    endgenerate

    assign sync_ptr_gray = w_sync_last;
    assign sync_ptr_bin  = r_sync_bin;
    assign advance       = r_advance;
    assign level         = w_level;
    assign flag          = w_flag;
    assign gray_err      = r_gray_err;

endmodule
`default_nettype wire
